// File: rtl/counter_ctrl.sv
// Command sequencer for an 8-bit up counter: LOAD / CLEAR / RUN_N / RUN_TO over
// a valid/ready handshake, with abort, run-to timeout, and a one-cycle DONE pulse.
module counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_arg,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_enable,
  output logic             o_load,
  output logic [WIDTH-1:0] o_data,
  output logic             o_done,
  output logic [1:0]       o_status
);

  typedef enum logic [2:0] {S_IDLE, S_LDST, S_RUNN, S_RUNTO, S_FINISH} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_RUNN  = 2'b01;
  localparam logic [1:0] OP_RUNTO = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_steps;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_status;

  logic             w_hit;

  assign w_hit = (i_count == r_target);

  // Enable/load must react to ABORT and COUNT within the cycle, so they are
  // decoded from the registered state rather than registered themselves.
  always_comb begin
    o_enable = 1'b0;
    o_load   = 1'b0;
    if (!i_rst && !i_abort) begin
      case (r_state)
        S_LDST:  begin o_enable = 1'b1; o_load = 1'b1; end
        S_RUNN:  o_enable = 1'b1;
        S_RUNTO: o_enable = !w_hit;
        default: ;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE)   && !i_rst;
  assign o_done      = (r_state == S_FINISH) && !i_rst;
  assign o_status    = o_done ? r_status : ST_OK;
  assign o_data      = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_steps  <= '0;
      r_target <= '0;
      r_data   <= '0;
      r_status <= ST_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_status <= ST_OK;
            case (i_cmd_op)
              OP_LOAD:  begin r_data <= i_cmd_arg; r_state <= S_LDST; end
              OP_CLEAR: begin r_data <= '0;        r_state <= S_LDST; end
              OP_RUNN: begin
                if (i_cmd_arg != '0) begin
                  r_rem   <= i_cmd_arg;
                  r_state <= S_RUNN;
                end else begin
                  r_state <= S_FINISH;
                end
              end
              OP_RUNTO: begin
                r_target <= i_cmd_arg;
                r_steps  <= '0;
                r_state  <= S_RUNTO;
              end
              default: ;
            endcase
          end
        end
        S_LDST: begin
          if (i_abort) r_status <= ST_ABORT;
          r_state <= S_FINISH;
        end
        S_RUNN: begin
          if (i_abort) begin
            r_status <= ST_ABORT;
            r_state  <= S_FINISH;
          end else begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == WIDTH'(1)) r_state <= S_FINISH;
          end
        end
        S_RUNTO: begin
          // steps counts enable cycles already spent; the 2^WIDTH-th one without
          // a match means the counter is not following us.
          if (i_abort) begin
            r_status <= ST_ABORT;
            r_state  <= S_FINISH;
          end else if (w_hit) begin
            r_state <= S_FINISH;
          end else if (r_steps == '1) begin
            r_status <= ST_TIMEOUT;
            r_state  <= S_FINISH;
          end else begin
            r_steps <= r_steps + 1'b1;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl driving a behavioural 8-bit up counter.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic [7:0] count;
  logic       en, ld, done;
  logic [7:0] data;
  logic [1:0] status;

  int vecs = 0;
  int errs = 0;
  int en_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_arg(cmd_arg), .i_abort(abort), .i_count(count),
    .o_enable(en), .o_load(ld), .o_data(data), .o_done(done), .o_status(status)
  );

  // Reference up counter with its own reset, independent of the controller.
  always @(posedge clk) begin
    if (cnt_rst)  count <= 8'd0;
    else if (en)  count <= ld ? data : count + 8'd1;
  end

  always @(posedge clk) begin
    if (en)   en_cnt   <= en_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  // Present a command in the current (idle) cycle; returns in cycle k+1.
  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    #1 chk("ready_at_accept", 32'(cmd_ready), 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    send(2'b00, v);
    cyc(); cyc();
  endtask

  // Returns the cycle index (relative to accept cycle k) in which DONE was seen.
  task automatic wait_done(input int lim, output int n);
    n = 1;
    #1;
    while (done !== 1'b1 && n < lim) begin
      cyc(); #1; n++;
    end
  endtask

  int base, n, dn_base;

  initial begin
    rst = 1'b1; cnt_rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_arg = 8'h00; abort = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_ready",  32'(cmd_ready), 0);
    chk("rst_enable", 32'(en), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_data",   32'(data), 0);
    cyc();
    rst = 1'b0; cnt_rst = 1'b0;
    #1 chk("ready_after_rst", 32'(cmd_ready), 1);

    // LOAD 0xA5
    cyc();
    send(2'b00, 8'hA5);
    #1;
    chk("load_en",   32'(en), 1);
    chk("load_ld",   32'(ld), 1);
    chk("load_data", 32'(data), 'hA5);
    cyc(); #1;
    chk("load_en_off", 32'(en), 0);
    chk("load_done",   32'(done), 1);
    chk("load_status", 32'(status), 0);
    chk("load_count",  32'(count), 'hA5);
    chk("load_busy",   32'(cmd_ready), 0);
    cyc(); #1;
    chk("load_ready_back", 32'(cmd_ready), 1);
    chk("load_done_once",  32'(done), 0);

    // RUN_N 3 across the wrap
    cyc();
    do_load(8'hFE);
    base = en_cnt;
    send(2'b01, 8'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("runn_en",   32'(en), 1);
      chk("runn_busy", 32'(cmd_ready), 0);
      cyc();
    end
    #1;
    chk("runn_done",   32'(done), 1);
    chk("runn_en_off", 32'(en), 0);
    chk("runn_count",  32'(count), 'h01);
    chk("runn_status", 32'(status), 0);
    chk("runn_busy_d", 32'(cmd_ready), 0);
    chk("runn_en_cnt", 32'(en_cnt - base), 3);
    cyc(); #1;
    chk("runn_ready_back", 32'(cmd_ready), 1);

    // RUN_N 0 and RUN_TO current count
    base = en_cnt;
    send(2'b01, 8'd0);
    #1;
    chk("run0_done",  32'(done), 1);
    chk("run0_en",    32'(en), 0);
    chk("run0_count", 32'(count), 'h01);
    cyc();
    send(2'b10, 8'h01);
    #1 chk("rtsame_en", 32'(en), 0);
    chk("rtsame_done_early", 32'(done), 0);
    cyc(); #1;
    chk("rtsame_done",   32'(done), 1);
    chk("rtsame_status", 32'(status), 0);
    chk("rtsame_count",  32'(count), 'h01);
    chk("zero_en_cnt",   32'(en_cnt - base), 0);
    cyc();

    // RUN_TO 0x10 from 0x20: distance 240
    do_load(8'h20);
    base = en_cnt;
    send(2'b10, 8'h10);
    wait_done(300, n);
    chk("rt_latency", 32'(n), 242);
    chk("rt_en_cnt",  32'(en_cnt - base), 240);
    chk("rt_count",   32'(count), 'h10);
    chk("rt_status",  32'(status), 0);
    cyc();

    // RUN_TO with the counter pinned in reset: timeout
    cnt_rst = 1'b1;
    base = en_cnt;
    send(2'b10, 8'h10);
    wait_done(300, n);
    chk("to_latency", 32'(n), 257);
    chk("to_en_cnt",  32'(en_cnt - base), 256);
    chk("to_status",  32'(status), 2);
    chk("to_count",   32'(count), 0);
    cyc();
    cnt_rst = 1'b0;

    // ABORT during RUN_N 50 after 7 enables
    do_load(8'h30);
    base = en_cnt;
    send(2'b01, 8'd50);
    repeat (7) cyc();
    abort = 1'b1;
    #1;
    chk("abort_en",        32'(en), 0);
    chk("abort_done_same", 32'(done), 0);
    cyc();
    abort = 1'b0;
    #1;
    chk("abort_done",   32'(done), 1);
    chk("abort_status", 32'(status), 1);
    chk("abort_count",  32'(count), 'h37);
    chk("abort_en_cnt", 32'(en_cnt - base), 7);
    cyc(); #1;
    chk("abort_ready_back", 32'(cmd_ready), 1);

    // ABORT wins over completion of RUN_N 1
    send(2'b01, 8'd1);
    abort = 1'b1;
    #1 chk("abwin_en", 32'(en), 0);
    cyc();
    abort = 1'b0;
    #1;
    chk("abwin_done",   32'(done), 1);
    chk("abwin_status", 32'(status), 1);
    chk("abwin_count",  32'(count), 'h37);
    cyc();

    // ABORT in IDLE is ignored; the command accepted alongside runs normally
    abort = 1'b1;
    send(2'b01, 8'd2);
    abort = 1'b0;
    #1 chk("idleab_en", 32'(en), 1);
    cyc(); cyc(); #1;
    chk("idleab_done",   32'(done), 1);
    chk("idleab_status", 32'(status), 0);
    chk("idleab_count",  32'(count), 'h39);
    cyc();

    // RESET mid RUN_N 20 with a command held valid across reset
    send(2'b01, 8'd20);
    cyc(); cyc(); cyc();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd2;
    dn_base = done_cnt;
    #1;
    chk("midrst_en",    32'(en), 0);
    chk("midrst_ready", 32'(cmd_ready), 0);
    chk("midrst_done",  32'(done), 0);
    chk("midrst_count", 32'(count), 'h3C);
    cyc(); #1;
    chk("midrst_ready2", 32'(cmd_ready), 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("postrst_ready", 32'(cmd_ready), 1);
    chk("postrst_count", 32'(count), 'h3C);
    chk("postrst_nodone", 32'(done_cnt - dn_base), 0);
    cyc();
    cmd_valid = 1'b0;
    #1 chk("postrst_en", 32'(en), 1);
    cyc(); #1 chk("postrst_en2", 32'(en), 1);
    cyc(); #1;
    chk("postrst_done",  32'(done), 1);
    chk("postrst_final", 32'(count), 'h3E);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
